// File: rtl/riscv_pkg.sv
// Shared RV32 definitions: data width, M-extension multiply variants and the
// iterative multiplier's FSM state encoding.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [1:0] MUL_OP_MUL    = 2'b00;
  localparam logic [1:0] MUL_OP_MULH   = 2'b01;
  localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
  localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } mul_state_t;

endpackage

// File: rtl/mul_iter.sv
// Iterative RV32M multiplier: sign-magnitude radix-2 shift-add over XLEN
// cycles, then sign fix-up and half-word select into a held result register.
module mul_iter
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = riscv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] Result
);

  localparam int unsigned CNT_W = $clog2(XLEN);
  localparam int unsigned ACC_W = 2 * XLEN;

  mul_state_t       state, state_d;
  logic [1:0]       op_q, op_d;
  logic [XLEN-1:0]  mag_a, mag_a_d;
  logic [XLEN-1:0]  mag_b, mag_b_d;
  logic             neg, neg_d;
  logic [ACC_W-1:0] acc, acc_d;
  logic [CNT_W-1:0] count, count_d;
  logic [XLEN-1:0]  result_d;
  logic             busy_d, done_d;

  logic             a_signed, b_signed, a_neg, b_neg;
  logic [XLEN:0]    sum;
  logic [ACC_W-1:0] product;

  // Operand signedness for the incoming request; partial-sum add with carry.
  always_comb begin
    a_signed = (op == MUL_OP_MULH) || (op == MUL_OP_MULHSU);
    b_signed = (op != MUL_OP_MUL) && (op != MUL_OP_MULHSU) && (op != MUL_OP_MULHU);
    a_neg    = a_signed && A[XLEN-1];
    b_neg    = b_signed && B[XLEN-1];
    sum      = {1'b0, acc[ACC_W-1:XLEN]} + (mag_b[0] ? {1'b0, mag_a} : '0);
    product  = neg ? -acc : acc;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state;
    op_d     = op_q;
    mag_a_d  = mag_a;
    mag_b_d  = mag_b;
    neg_d    = neg;
    acc_d    = acc;
    count_d  = count;
    result_d = Result;
    busy_d   = 1'b0;
    done_d   = 1'b0;

    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          op_d    = op;
          mag_a_d = a_neg ? -A : A;
          mag_b_d = b_neg ? -B : B;
          neg_d   = a_neg ^ b_neg;
          acc_d   = '0;
          count_d = CNT_W'(XLEN - 1);
          state_d = ST_CALC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        // {carry, acc} >> 1 after adding into the upper half.
        acc_d   = {sum, acc[XLEN-1:1]};
        mag_b_d = mag_b >> 1;
        if (count == '0) state_d = ST_FIX;
        else             count_d = count - CNT_W'(1);
      end
      ST_FIX: begin
        result_d = (op_q == MUL_OP_MUL) ? product[XLEN-1:0] : product[ACC_W-1:XLEN];
        state_d  = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_CALC) || (state_d == ST_FIX);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      op_q   <= MUL_OP_MUL;
      mag_a  <= '0;
      mag_b  <= '0;
      neg    <= 1'b0;
      acc    <= '0;
      count  <= '0;
      Result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_d;
      op_q   <= op_d;
      mag_a  <= mag_a_d;
      mag_b  <= mag_b_d;
      neg    <= neg_d;
      acc    <= acc_d;
      count  <= count_d;
      Result <= result_d;
      busy   <= busy_d;
      done   <= done_d;
    end
  end

endmodule

// File: tb/tb_mul_iter.sv
// Self-checking bench for mul_iter: directed vector table, back-to-back,
// interference and reset sequences, plus random ops against a 64-bit model.
module tb_mul_iter;
  import riscv_pkg::*;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op    = 2'b00;
  logic [31:0] A     = 32'h0;
  logic [31:0] B     = 32'h0;
  logic        busy, done;
  logic [31:0] Result;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_result = 32'h0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [10];

  always #5 clk = ~clk;

  mul_iter #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .A(A), .B(B), .busy(busy), .done(done), .Result(Result)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic check_bit(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", nm, act, exp);
    end
  endtask

  // Exact product of the operands extended per variant, then pick a half.
  function automatic logic [31:0] ref_mul(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = (o == MUL_OP_MULH || o == MUL_OP_MULHSU) ? {{32{a[31]}}, a} : {32'h0, a};
    eb = (o == MUL_OP_MULH) ? {{32{b[31]}}, b} : {32'h0, b};
    p  = ea * eb;
    return (o == MUL_OP_MUL) ? p[31:0] : p[63:32];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start in the current cycle (cycle 0) and check cycles 1..34.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input bit interfere, input string nm);
    op = o; A = a; B = b; start = 1'b1;
    for (int c = 1; c <= 34; c++) begin
      tick();
      if (c == 1) start = 1'b0;
      if (interfere && c == 10) begin
        A = ~a; B = a ^ b ^ 32'h1234_5678; op = ~o; start = 1'b1;
      end
      if (interfere && c == 11) start = 1'b0;
      check_bit($sformatf("%s c%0d busy", nm, c), busy, c <= 33);
      check_bit($sformatf("%s c%0d done", nm, c), done, c == 34);
      check($sformatf("%s c%0d result", nm, c), Result, (c == 34) ? exp : last_result);
    end
    last_result = exp;
  endtask

  initial begin
    logic [1:0]  o;
    logic [31:0] a, b;

    tbl[0] = '{MUL_OP_MUL,    32'd7,         32'd6,         32'h0000_002A};
    tbl[1] = '{MUL_OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    tbl[2] = '{MUL_OP_MULH,   32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF};
    tbl[3] = '{MUL_OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    tbl[4] = '{MUL_OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
    tbl[5] = '{MUL_OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    tbl[6] = '{MUL_OP_MULHSU, 32'h0000_0002, 32'h8000_0000, 32'h0000_0001};
    tbl[7] = '{MUL_OP_MULH,   32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF};
    tbl[8] = '{MUL_OP_MUL,    32'h8000_0000, 32'h8000_0000, 32'h0000_0000};
    tbl[9] = '{MUL_OP_MULH,   32'h0000_0000, 32'h8000_0000, 32'h0000_0000};

    // Asynchronous reset: outputs clear before any clock edge.
    #1 rst_n = 1'b0;
    #2;
    check_bit("reset busy", busy, 1'b0);
    check_bit("reset done", done, 1'b0);
    check("reset result", Result, 32'h0);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();

    foreach (tbl[i]) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp, 1'b0, $sformatf("vec%0d", i));
      tick();
    end

    // Ignored start plus operand changes mid-operation.
    run_op(MUL_OP_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b1, "interfere");
    tick();

    // Back-to-back: second start accepted in the DONE cycle.
    run_op(MUL_OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, "b2b_first");
    run_op(MUL_OP_MUL, 32'd123, 32'd1000, 32'd123000, 1'b0, "b2b_second");
    tick();

    // Reset in cycle 15 of an operation.
    op = MUL_OP_MUL; A = 32'd9; B = 32'd9; start = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      tick();
      start = 1'b0;
    end
    check_bit("pre-reset busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check_bit("midreset busy", busy, 1'b0);
    check_bit("midreset done", done, 1'b0);
    check("midreset result", Result, 32'h0);
    tick();
    @(negedge clk) rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      tick();
      check_bit($sformatf("postreset c%0d done", c), done, 1'b0);
      check_bit($sformatf("postreset c%0d busy", c), busy, 1'b0);
    end
    last_result = 32'h0;
    run_op(MUL_OP_MUL, 32'd3, 32'd5, 32'h0000_000F, 1'b0, "mul3x5");
    tick();

    // Random operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 4) == 0) a = 32'h8000_0000;
      if ($urandom_range(0, 4) == 0) b = 32'hFFFF_FFFF;
      run_op(o, a, b, ref_mul(o, a, b), $urandom_range(0, 3) == 0, $sformatf("rnd%0d", i));
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_iter.md
# mul_iter

Iterative RV32M multiply unit for the multicycle core. Accepts two 32-bit operands and a multiply variant, computes the product with a radix-2 shift-add over a fixed number of cycles, and holds the selected 32-bit half of the result. The result register drives one input of the 8:1 write-back select mux. The control FSM pulses `start` and waits for `done` before selecting that mux input.

## Interface
- `XLEN`, default 32: operand and result width. Only 32 is supported and verified.
- `clk` input, 1 bit: single clock, rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `start` input, 1 bit: request a new multiply. Sampled only when `busy`=0.
- `op` input, 2 bits: 00 MUL (low word), 01 MULH (s×s, high), 10 MULHSU (s×u, high), 11 MULHU (u×u, high).
- `A` input, 32 bits: rs1 operand. Captured when `start` is accepted.
- `B` input, 32 bits: rs2 operand. Captured when `start` is accepted.
- `busy` output, 1 bit: high in CALC and FIX.
- `done` output, 1 bit: one-cycle pulse, high in DONE.
- `Result` output, 32 bits: last completed result, held until the next completion.

## Operation
- States are IDLE, CALC, FIX and DONE.
- IDLE:
  - `start`=1 latches `op`, |A| and |B| into 32-bit magnitude registers and the sign flag `neg`.
  - Clears the 64-bit accumulator, loads count=31, and goes to CALC.
- Magnitude rules:
  - A is treated as signed for MULH and MULHSU; B is signed for MULH only. An unsigned operand passes through unchanged.
  - |−2^31| = 0x80000000 as an unsigned 32-bit value. This requires no special case.
- `neg` = (A signed and A[31]) XOR (B signed and B[31]).
- CALC:
  - Each cycle: if mag_B bit 0 is set, add mag_A to accumulator[63:32] with the carry kept in a 65th bit. Then shift {carry, acc} right by 1 and shift mag_B right by 1.
  - When count=0, go to FIX; otherwise decrement count.
- FIX:
  - The product is the two's-complement negation of acc (64-bit) if `neg`, else acc unchanged.
  - `Result` = product[31:0] for MUL, product[63:32] otherwise.
  - Go to DONE.
- DONE:
  - `done`=1.
  - `start`=1 here is accepted exactly as in IDLE and goes to CALC (back-to-back). Otherwise go to IDLE.
- `start` while `busy`=1 is ignored and has no effect.
- Changes to A, B or `op` after acceptance have no effect.
- MUL result is independent of signedness; the `op`=00 path treats both operands as unsigned.

## Timing
- Reset (async, `rst_n`=0): state=IDLE, `busy`=0, `done`=0, `Result`=0, count=0, accumulator=0. Outputs take these values immediately, not at the next edge.
- Reset mid-operation aborts the multiply. No `done` is produced, and `Result` reads 0.
- Latency: `start` high in cycle 0 means CALC occupies cycles 1–32, FIX cycle 33, and DONE cycle 34.
  - `done`=1 and the new `Result` are valid in cycle 34. Latency is 34 cycles and independent of operand values.
- `busy`=1 in cycles 1–33, 0 in cycle 34.
- Throughput with back-to-back starts is one result per 34 cycles.
- `Result` changes only on the FIX→DONE edge and is stable otherwise, including throughout the next operation until its FIX.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package `riscv_pkg` holds:
  - the `op` encodings MUL_OP_MUL, MUL_OP_MULH, MUL_OP_MULHSU, MUL_OP_MULHU;
  - the FSM state encoding constants;
  - XLEN=32.
- Single module with no sub-module. The adder, shifter and FSM are small enough to keep inline.
- Approximately 150–250 lines of RTL.

## Test plan
- MUL 7 × 6: `start` in cycle 0 -> `done` in cycle 34 only, `Result`=0x0000002A, `busy` high in cycles 1–33.
- MULH 0x80000000 × 0x80000000 -> 0x40000000. MULH 0xFFFFFFFF × 0x00000002 -> 0xFFFFFFFF.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE. MUL on the same operands -> 0x00000001.
- MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF. MULHSU 0x00000002 × 0x80000000 -> 0x00000001.
- Operand and `start` interference:
  - Change A and B and pulse `start` in cycle 10 -> ignored, original result delivered in cycle 34.
  - `start` in the DONE cycle (34) -> second `done` in cycle 68 with the correct second result. First `Result` is held in cycles 35–67.
- Reset mid-operation:
  - `rst_n` low in cycle 15 -> `busy`, `done` and `Result` go to 0 immediately.
  - After release, a new MUL 3 × 5 returns 0x0000000F after 34 cycles.
  - No spurious `done` occurs.
